vga_cmd_proc: RTL

- Parametrised command processor for the ice40 VGA controller.
- Consumes command/data bytes from the shared command register.
- Decodes multi-byte commands: pixel data, font load, foreground colour, background colour.
- Drives the pixel register, the colour registers and the font block-RAM write port, which feed the pixel generator.

---
 rtl/vga_cmd_pkg.sv | 25 ++
 rtl/vga_color_latch.sv | 36 +++
 rtl/vga_cmd_proc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vga_cmd_pkg.sv
// rtl/vga_cmd_pkg.sv - opcodes, FSM states and default colours for vga_cmd_proc
package vga_cmd_pkg;

  // Opcode bytes double as the active-command encoding; CMD_NONE is also the NOP byte.
  typedef enum logic [7:0] {
    CMD_NONE      = 8'h00,
    CMD_LOAD_FONT = 8'h80,
    CMD_PIXDATA   = 8'h81,
    CMD_SET_FG    = 8'h82,
    CMD_SET_BG    = 8'h83
  } cmd_e;

  typedef enum logic {
    ST_READY   = 1'b0,
    ST_PROCESS = 1'b1
  } state_e;

  localparam logic [11:0] DEF_FG = 12'hFF0;
  localparam logic [11:0] DEF_BG = 12'h208;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_color_latch.sv
// rtl/vga_color_latch.sv - R/G shadow bytes with atomic {R,G,B} commit on the B byte
module vga_color_latch #(
  parameter int                   COLOR_W   = 4,
  parameter logic [3*COLOR_W-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   abort,
  input  logic                   byte_we,
  input  logic [1:0]             byte_idx,
  input  logic [COLOR_W-1:0]     byte_data,
  output logic [3*COLOR_W-1:0]   color
);

  logic [COLOR_W-1:0] sh_r;
  logic [COLOR_W-1:0] sh_g;

  always_ff @(posedge clk) begin
    if (nrst) begin
      sh_r  <= '0;
      sh_g  <= '0;
      color <= RESET_VAL;
    end else if (abort) begin
      sh_r <= '0;
      sh_g <= '0;
    end else if (byte_we) begin
      case (byte_idx)
        2'd0:    sh_r  <= byte_data;
        2'd1:    sh_g  <= byte_data;
        2'd2:    color <= {sh_r, sh_g, byte_data};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vga_cmd_proc.sv
// rtl/vga_cmd_proc.sv - byte-stream command processor for the VGA pixel/colour/font registers; VGA_CMD_TIMEOUT_EN adds a stall timeout
module vga_cmd_proc
  import vga_cmd_pkg::*;
#(
  parameter int                   PIX_BYTES   = 1,
  parameter int                   FONT_ADDR_W = 12,
  parameter int                   COLOR_W     = 4,
  parameter logic [3*COLOR_W-1:0] FG_RESET    = DEF_FG,
  parameter logic [3*COLOR_W-1:0] BG_RESET    = DEF_BG,
  parameter int                   TIMEOUT_W   = 20
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_rd,
  output logic [8*PIX_BYTES-1:0]   pixreg,
  output logic [3*COLOR_W-1:0]     fg_color,
  output logic [3*COLOR_W-1:0]     bg_color,
  output logic                     font_we,
  output logic [FONT_ADDR_W-1:0]   font_addr,
  output logic [7:0]               font_wdata,
  output logic                     busy,
  output logic [7:0]               err_cnt
);

  localparam int PIX_W = 8 * PIX_BYTES;
  localparam int CNT_W = (FONT_ADDR_W > 8) ? FONT_ADDR_W : 8;
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(PIX_BYTES - 1);
  localparam logic [CNT_W-1:0] FONT_LAST = CNT_W'((1 << FONT_ADDR_W) - 1);
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(2);

  state_e             st;
  state_e             st_nxt;
  cmd_e               active_cmd;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         data_q;
  logic [PIX_W-1:0]   pix_sh;
  logic [PIX_W-1:0]   pix_next;
  logic               proc;
  logic               fg_we;
  logic               bg_we;
  logic               timeout_abort;

  always_ff @(posedge clk) begin
    if (nrst) st <= ST_READY;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    in_rd  = 1'b0;
    case (st)
      ST_READY: begin
        if (in_valid && !nrst) begin
          in_rd  = 1'b1;
          st_nxt = ST_PROCESS;
        end
      end
      ST_PROCESS: st_nxt = ST_READY;
      default:    st_nxt = ST_READY;
    endcase
  end

  assign proc       = (st == ST_PROCESS);
  assign busy       = (active_cmd != CMD_NONE);
  assign font_we    = proc && (active_cmd == CMD_LOAD_FONT);
  assign font_addr  = cnt[FONT_ADDR_W-1:0];
  assign font_wdata = data_q;
  assign fg_we      = proc && (active_cmd == CMD_SET_FG);
  assign bg_we      = proc && (active_cmd == CMD_SET_BG);

  // Shift in MSB byte first; the oldest byte falls off the top.
  always_comb begin
    pix_next      = pix_sh << 8;
    pix_next[7:0] = data_q;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      active_cmd <= CMD_NONE;
      cnt        <= '0;
      data_q     <= '0;
      pix_sh     <= '0;
      pixreg     <= '0;
      err_cnt    <= '0;
    end else begin
      if (in_rd) data_q <= in_data;
      if (timeout_abort) begin
        active_cmd <= CMD_NONE;
        cnt        <= '0;
        pix_sh     <= '0;
        err_cnt    <= sat_inc8(err_cnt);
      end else if (proc) begin
        case (active_cmd)
          CMD_NONE: begin
            cnt <= '0;
            case (data_q)
              CMD_NONE:      ;
              CMD_LOAD_FONT: active_cmd <= CMD_LOAD_FONT;
              CMD_PIXDATA:   active_cmd <= CMD_PIXDATA;
              CMD_SET_FG:    active_cmd <= CMD_SET_FG;
              CMD_SET_BG:    active_cmd <= CMD_SET_BG;
              default:       err_cnt    <= sat_inc8(err_cnt);
            endcase
          end
          CMD_LOAD_FONT: begin
            if (cnt == FONT_LAST) begin
              cnt        <= '0;
              active_cmd <= CMD_NONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          CMD_PIXDATA: begin
            pix_sh <= pix_next;
            if (cnt == PIX_LAST) begin
              pixreg     <= pix_next;
              cnt        <= '0;
              active_cmd <= CMD_NONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          CMD_SET_FG, CMD_SET_BG: begin
            if (cnt == COL_LAST) begin
              cnt        <= '0;
              active_cmd <= CMD_NONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            cnt        <= '0;
            active_cmd <= CMD_NONE;
          end
        endcase
      end
    end
  end

`ifdef VGA_CMD_TIMEOUT_EN
  // Abort on the edge where the idle count would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] TO_NEAR = ~TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 to_idle;

  assign to_idle       = busy && (st == ST_READY) && !in_valid;
  assign timeout_abort = to_idle && (to_cnt == TO_NEAR);

  always_ff @(posedge clk) begin
    if (nrst || !busy || in_rd || timeout_abort) to_cnt <= '0;
    else if (to_idle)                            to_cnt <= to_cnt + TIMEOUT_W'(1);
  end
`else
  assign timeout_abort = (TIMEOUT_W < 0);
`endif

  vga_color_latch #(
    .COLOR_W   (COLOR_W),
    .RESET_VAL (FG_RESET)
  ) u_fg (
    .clk       (clk),
    .nrst      (nrst),
    .abort     (timeout_abort),
    .byte_we   (fg_we),
    .byte_idx  (cnt[1:0]),
    .byte_data (data_q[COLOR_W-1:0]),
    .color     (fg_color)
  );

  vga_color_latch #(
    .COLOR_W   (COLOR_W),
    .RESET_VAL (BG_RESET)
  ) u_bg (
    .clk       (clk),
    .nrst      (nrst),
    .abort     (timeout_abort),
    .byte_we   (bg_we),
    .byte_idx  (cnt[1:0]),
    .byte_data (data_q[COLOR_W-1:0]),
    .color     (bg_color)
  );

endmodule
